// File: rtl/arbitrated_req_queue_pkg.sv
// Shared defines for the arbitrated request queue: default sizing and source-index type.
package arbitrated_req_queue_pkg;

  localparam int unsigned NUM_REQUESTERS_DFLT = 4;
  localparam int unsigned DATA_WIDTH_DFLT     = 32;
  localparam int unsigned FIFO_DEPTH_DFLT     = 4;

  // Index width for an n-entry one-hot set; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned SRC_W = idx_width(NUM_REQUESTERS_DFLT);

  typedef logic [SRC_W-1:0] src_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority rotates to the entry after the last granted one on update_lru.
module rr_arbiter
  import arbitrated_req_queue_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = NUM_REQUESTERS_DFLT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update_lru,
  output logic [NUM_REQUESTERS-1:0] grant_oh
);

  localparam int unsigned IW = idx_width(NUM_REQUESTERS);

  logic [IW-1:0] ptr;
  logic [IW-1:0] grant_idx;
  logic          found;
  int unsigned   idx;

  // Scan from the highest-priority index upward, wrapping around.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      idx = (32'(ptr) + i) % NUM_REQUESTERS;
      if (!found && request[IW'(idx)]) begin
        grant_oh[IW'(idx)] = 1'b1;
        grant_idx          = IW'(idx);
        found              = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (update_lru && found) begin
      ptr <= (32'(grant_idx) == NUM_REQUESTERS - 1) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/arbitrated_req_queue.sv
// Per-requester FIFOs feeding a round-robin arbitrated single-entry output slot.
// Optional ARB_QUEUE_BYPASS_EN: an input may load the slot directly when all FIFOs are empty.
module arbitrated_req_queue
  import arbitrated_req_queue_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = NUM_REQUESTERS_DFLT,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DFLT,
  parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_DFLT
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_REQUESTERS-1:0]                 in_valid,
  input  logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0] in_data,
  output logic [NUM_REQUESTERS-1:0]                 in_ready,
  output logic                                      out_valid,
  output logic [DATA_WIDTH-1:0]                     out_data,
  output logic [$clog2(NUM_REQUESTERS)-1:0]         out_source,
  input  logic                                      out_ready
);

  localparam int unsigned SRC_W = $clog2(NUM_REQUESTERS);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem    [NUM_REQUESTERS][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr [NUM_REQUESTERS];
  logic [PTR_W-1:0]      rd_ptr [NUM_REQUESTERS];
  logic [CNT_W-1:0]      count  [NUM_REQUESTERS];

  logic [NUM_REQUESTERS-1:0] fifo_req;
  logic [NUM_REQUESTERS-1:0] arb_req;
  logic [NUM_REQUESTERS-1:0] grant_oh;
  logic [NUM_REQUESTERS-1:0] push;
  logic [NUM_REQUESTERS-1:0] pop;
  logic [SRC_W-1:0]          grant_idx;
  logic [DATA_WIDTH-1:0]     head_data;
  logic                      slot_free;
  logic                      bypass;
  logic                      advance;

  always_comb begin
    in_ready  = '0;
    fifo_req  = '0;
    grant_idx = '0;
    push      = '0;
    pop       = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      in_ready[i] = (count[i] != CNT_W'(FIFO_DEPTH)) && !reset;
      fifo_req[i] = (count[i] != '0);
    end
    slot_free = !out_valid || out_ready;
`ifdef ARB_QUEUE_BYPASS_EN
    // With every FIFO empty the arbiter sees raw in_valid and the winner skips its FIFO.
    bypass  = slot_free && !(|fifo_req);
    arb_req = bypass ? in_valid : fifo_req;
`else
    bypass  = 1'b0;
    arb_req = fifo_req;
`endif
    advance = slot_free && (|arb_req);
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant_oh[i]) grant_idx = SRC_W'(i);
    end
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      push[i] = in_valid[i] && in_ready[i] && !(bypass && grant_oh[i]);
      pop[i]  = advance && !bypass && grant_oh[i];
    end
    head_data = bypass ? in_data[grant_idx] : mem[grant_idx][rd_ptr[grant_idx]];
  end

  rr_arbiter #(
    .NUM_REQUESTERS (NUM_REQUESTERS)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .request    (arb_req),
    .update_lru (advance),
    .grant_oh   (grant_oh)
  );

  // FIFO bookkeeping; a full FIFO never takes a push, so push and pop are independent.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (reset) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end else begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_source <= '0;
    end else if (advance) begin
      out_valid  <= 1'b1;
      out_data   <= head_data;
      out_source <= grant_idx;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arbitrated_req_queue.sv
// Directed self-checking bench for arbitrated_req_queue (default 4 x 32-bit, depth 4).
module tb_arbitrated_req_queue;
  import arbitrated_req_queue_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       in_valid;
  logic [3:0][31:0] in_data;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [31:0]      out_data;
  src_idx_t         out_source;
  logic             out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  arbitrated_req_queue dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_source (out_source),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_slot(input string tag, input logic [31:0] d, input logic [1:0] s);
    check({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
    check({tag, "_data"}, 64'(out_data), 64'(d));
    check({tag, "_src"}, 64'(out_source), 64'(s));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready", 64'(in_ready), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_source", 64'(out_source), 64'h0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'hF);

    // Single push on requester 2: latency check.
    in_valid   = 4'b0100;
    in_data[2] = 32'hA5;
    step();
    in_valid = '0;
`ifdef ARB_QUEUE_BYPASS_EN
    check_slot("lat_bypass", 32'hA5, 2'd2);
`else
    check("lat_e0_valid", 64'(out_valid), 64'h0);
    step();
    check_slot("lat_e1", 32'hA5, 2'd2);
`endif
    out_ready = 1'b1;
    step();
    check("lat_drain_valid", 64'(out_valid), 64'h0);

    // Restore arbiter priority to requester 0 before the fairness run.
    reset = 1'b1;
    step();
    reset     = 1'b0;
    out_ready = 1'b0;

    // Two entries per requester, then drain with out_ready high.
    in_valid = 4'hF;
    for (int i = 0; i < 4; i++) in_data[i] = 32'h100 * i;
    step();
    for (int i = 0; i < 4; i++) in_data[i] = 32'h100 * i + 1;
    step();
    in_valid  = '0;
    out_ready = 1'b1;
    #1;
    check_slot("rr0", 32'h000, 2'd0);
    for (int k = 1; k < 8; k++) begin
      step();
      check_slot($sformatf("rr%0d", k), 32'h100 * (k % 4) + 32'(k / 4), 2'(k % 4));
    end
    step();
    check("rr_end_valid", 64'(out_valid), 64'h0);

    // Backpressure: five pushes on requester 1 with out_ready low.
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      in_data[1] = 32'hB0 + 32'(k);
      step();
      if (k == 1) check_slot("bp_first", 32'hB0, 2'd1);
    end
    check("bp_in_ready_full", 64'(in_ready), 64'hD);
    check("bp_hold_data", 64'(out_data), 64'hB0);
    in_data[1] = 32'hB5;
    step();
    check("bp_in_ready_still", 64'(in_ready), 64'hD);
    check_slot("bp_hold", 32'hB0, 2'd1);
    in_valid  = '0;
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      check_slot($sformatf("bp_drain%0d", k), 32'hB0 + 32'(k), 2'd1);
    end
    step();
    check("bp_end_valid", 64'(out_valid), 64'h0);

    // Full requester 0 with in_valid held through the pop cycle.
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      in_data[0] = 32'hC0 + 32'(k);
      step();
    end
    in_data[0] = 32'hC5;
    out_ready  = 1'b1;
    #1;
    check("full_in_ready", 64'(in_ready[0]), 64'h0);
    check("full_slot_c0", 64'(out_data), 64'hC0);
    step();
    check("full_pop_c1", 64'(out_data), 64'hC1);
    check("full_ready_after", 64'(in_ready[0]), 64'h1);
    step();
    in_valid = '0;
    for (int k = 2; k < 6; k++) begin
      check_slot($sformatf("full_order%0d", k), 32'hC0 + 32'(k), 2'd0);
      step();
    end
    check("full_end_valid", 64'(out_valid), 64'h0);

    // Reset with 3 entries buffered on requester 2 and the slot valid.
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      in_data[2] = 32'hD0 + 32'(k);
      step();
    end
    in_valid = '0;
    check_slot("mid_pre", 32'hD0, 2'd2);
    reset = 1'b1;
    step();
    check("mid_rst_valid", 64'(out_valid), 64'h0);
    check("mid_rst_in_ready", 64'(in_ready), 64'h0);
    reset = 1'b0;
    #1;
    check("mid_post_in_ready", 64'(in_ready), 64'hF);
    in_valid   = 4'b1010;
    in_data[1] = 32'hE1;
    in_data[3] = 32'hE3;
    step();
    in_valid = '0;
    step();
    check_slot("mid_grant_low", 32'hE1, 2'd1);
    out_ready = 1'b1;
    step();
    check_slot("mid_grant_next", 32'hE3, 2'd3);
    step();
    check("mid_end_valid", 64'(out_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
